// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle for wb_ram_arbiter: packed per-master Wishbone request lanes plus the
// single RAM-side Wishbone port. "slave" is the arbiter's view, "master" the environment's.
interface wb_ram_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 3
);
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS-1:0]    m_lock_i;
    logic [32*NUM_MASTERS-1:0] m_adr_i;
    logic [32*NUM_MASTERS-1:0] m_dat_i;
    logic [4*NUM_MASTERS-1:0]  m_sel_i;
    logic [31:0]               m_dat_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic [NUM_MASTERS-1:0]    m_rty_o;

    logic        p_wb_CYC_O;
    logic        p_wb_STB_O;
    logic        p_wb_WE_O;
    logic        p_wb_LOCK_O;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_DAT_I;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;
    logic        p_wb_RTY_I;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O, p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O,
        input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O, p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O,
        output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
    );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one RAM port between DMA masters, with
// LOCK support, a per-grant beat quota (forced RTY) and a stalled-slave watchdog (ERR).
module wb_ram_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned MAX_BEATS   = 64,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   p_clk,
    input  logic                   p_reset,
    wb_ram_arbiter_if.slave        bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned BW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, GRANTED} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [WW-1:0]          wait_q, wait_d;

    logic                   g_cyc, g_stb, g_we, g_lock;
    logic [31:0]            g_adr, g_dat;
    logic [3:0]             g_sel;
    logic [NUM_MASTERS-1:0] g_mask;
    logic                   granted, term, quota_hit, stb_req, wd_fire, stb_fwd;
    logic                   found;
    logic [IW-1:0]          win;

    // Select the request lane of the master held in last_q (the current grant holder)
    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_lock = 1'b0;
        g_adr  = '0;
        g_dat  = '0;
        g_sel  = '0;
        g_mask = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (last_q == IW'(i)) begin
                g_cyc     = bus.m_cyc_i[i];
                g_stb     = bus.m_stb_i[i];
                g_we      = bus.m_we_i[i];
                g_lock    = bus.m_lock_i[i];
                g_adr     = bus.m_adr_i[32*i +: 32];
                g_dat     = bus.m_dat_i[32*i +: 32];
                g_sel     = bus.m_sel_i[4*i +: 4];
                g_mask[i] = 1'b1;
            end
        end
    end

    // Quota blocks an STB before it reaches the slave; the watchdog only fires if the slave stays silent
    always_comb begin
        granted   = (state_q == GRANTED);
        term      = bus.p_wb_ACK_I | bus.p_wb_ERR_I | bus.p_wb_RTY_I;
        quota_hit = (MAX_BEATS > 0) && granted && g_cyc && g_stb && !g_lock
                    && (beat_q == BW'(MAX_BEATS));
        stb_req   = granted && g_cyc && g_stb && !quota_hit;
        wd_fire   = stb_req && !term && (wait_q == WW'(TIMEOUT));
        stb_fwd   = stb_req && !wd_fire;
    end

    always_comb begin
        bus.p_wb_CYC_O  = granted && g_cyc && !wd_fire;
        bus.p_wb_STB_O  = stb_fwd;
        bus.p_wb_WE_O   = granted && g_we;
        bus.p_wb_LOCK_O = granted && g_lock;
        bus.p_wb_ADR_O  = granted ? g_adr : 32'h0;
        bus.p_wb_DAT_O  = granted ? g_dat : 32'h0;
        bus.p_wb_SEL_O  = granted ? g_sel : 4'hF;
        bus.m_dat_o     = granted ? bus.p_wb_DAT_I : 32'h0;
        bus.m_ack_o     = (granted && bus.p_wb_ACK_I) ? g_mask : '0;
        bus.m_err_o     = ((granted && bus.p_wb_ERR_I) || wd_fire) ? g_mask : '0;
        bus.m_rty_o     = ((granted && bus.p_wb_RTY_I) || quota_hit) ? g_mask : '0;
        timeout_o       = wd_fire;
        grant_o         = grant_q;
    end

    // Next-state: rotating-priority search in IDLE, counters and release in GRANTED
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        found   = 1'b0;
        win     = '0;
        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!found && (IW'(i) > last_q) && bus.m_cyc_i[i]) begin
                        found = 1'b1;
                        win   = IW'(i);
                    end
                end
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!found && (IW'(i) <= last_q) && bus.m_cyc_i[i]) begin
                        found = 1'b1;
                        win   = IW'(i);
                    end
                end
                if (found) begin
                    grant_d = NUM_MASTERS'(1) << win;
                    last_d  = win;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (stb_fwd && bus.p_wb_ACK_I && (beat_q != BW'(MAX_BEATS))) begin
                    beat_d = beat_q + BW'(1);
                end
                if (!stb_fwd || term) begin
                    wait_d = '0;
                end else if (wait_q != WW'(TIMEOUT)) begin
                    wait_d = wait_q + WW'(1);
                end
                if (wd_fire || quota_hit || (!g_cyc && !g_lock)) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: single burst, round robin, quota, watchdog,
// LOCK hold and asynchronous reset mid-burst.
module tb_wb_ram_arbiter;
    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] grant;
    logic         tmo;
    logic         ack_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter_if #(.NUM_MASTERS(N)) bus ();

    wb_ram_arbiter #(
        .NUM_MASTERS(N),
        .MAX_BEATS  (64),
        .TIMEOUT    (255)
    ) dut (
        .p_clk    (clk),
        .p_reset  (rst),
        .bus      (bus),
        .grant_o  (grant),
        .timeout_o(tmo)
    );

    // Zero-wait slave: acknowledges every forwarded STB when enabled
    assign bus.p_wb_ACK_I = ack_en & bus.p_wb_STB_O;
    assign bus.p_wb_DAT_I = bus.p_wb_ADR_O ^ 32'hFFFF_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic lock,
                         input logic [31:0] adr);
        bus.m_cyc_i[m]          = cyc;
        bus.m_stb_i[m]          = stb;
        bus.m_we_i[m]           = 1'b1;
        bus.m_lock_i[m]         = lock;
        bus.m_adr_i[32*m +: 32] = adr;
        bus.m_dat_i[32*m +: 32] = adr ^ 32'h0000_00A5;
        bus.m_sel_i[4*m +: 4]   = 4'h5;
    endtask

    task automatic idle_all();
        for (int m = 0; m < N; m++) drive(m, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ack_en = 1'b0;
        idle_all();
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int idx_of(input logic [N-1:0] oh);
        if (oh == 3'b001) return 0;
        if (oh == 3'b010) return 1;
        if (oh == 3'b100) return 2;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acks;
        int seq[$];
        int gap;
        int beats;
        int cur;
        int fired;
        logic [N-1:0] prev;
        logic rty_seen;

        bus.p_wb_ERR_I = 1'b0;
        bus.p_wb_RTY_I = 1'b0;
        ack_en = 1'b0;
        idle_all();
        rst = 1'b1;
        step();
        step();

        // Reset values
        check("rst_grant", grant, 3'b000);
        check("rst_cyc", bus.p_wb_CYC_O, 1'b0);
        check("rst_stb", bus.p_wb_STB_O, 1'b0);
        check("rst_sel", bus.p_wb_SEL_O, 4'hF);
        check("rst_adr", bus.p_wb_ADR_O, 32'h0);
        check("rst_ack", bus.m_ack_o, 3'b000);
        check("rst_dat_o", bus.m_dat_o, 32'h0);
        check("rst_tmo", tmo, 1'b0);

        // Single master 0: four write beats
        rst = 1'b0;
        ack_en = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h4100_0000);
        #1;
        check("t1_grant_pre", grant, 3'b000);
        check("t1_cyc_pre", bus.p_wb_CYC_O, 1'b0);
        step();
        check("t1_grant", grant, 3'b001);
        check("t1_dat_o", bus.m_dat_o, 32'hBEFF_0000);
        acks = 0;
        for (int b = 0; b < 4; b++) begin
            check("t1_cyc", bus.p_wb_CYC_O, 1'b1);
            check("t1_adr", bus.p_wb_ADR_O, 32'h4100_0000 + 32'(4 * b));
            check("t1_wdat", bus.p_wb_DAT_O, (32'h4100_0000 + 32'(4 * b)) ^ 32'hA5);
            check("t1_sel", bus.p_wb_SEL_O, 4'h5);
            check("t1_ack", bus.m_ack_o, 3'b001);
            if (bus.m_ack_o[0]) acks++;
            if (b < 3) drive(0, 1'b1, 1'b1, 1'b0, 32'h4100_0000 + 32'(4 * (b + 1)));
            else drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
            if (b < 3) step();
        end
        #1;
        check("t1_cyc_drop", bus.p_wb_CYC_O, 1'b0);
        check("t1_ack_count", acks, 4);
        step();
        check("t1_release", grant, 3'b000);

        // Round robin with 2-beat cycles from all three masters
        do_reset();
        ack_en = 1'b1;
        for (int m = 0; m < N; m++) drive(m, 1'b1, 1'b1, 1'b0, 32'h100 * m);
        prev = '0;
        gap = 0;
        beats = 0;
        cur = -1;
        for (int c = 0; c < 60 && seq.size() < 6; c++) begin
            step();
            if (grant != '0 && prev == '0) begin
                cur = idx_of(grant);
                seq.push_back(cur);
                if (seq.size() > 1) check("t2_gap", gap, 1);
                gap = 0;
                beats = 0;
            end
            if (grant == '0) begin
                gap++;
                for (int m = 0; m < N; m++) drive(m, 1'b1, 1'b1, 1'b0, 32'h100 * m);
            end else if (cur >= 0 && bus.m_ack_o[cur]) begin
                beats++;
                if (beats == 2) drive(cur, 1'b0, 1'b0, 1'b0, 32'h0);
            end
            prev = grant;
        end
        check("t2_grants", seq.size(), 6);
        for (int k = 0; k < seq.size(); k++) check("t2_order", seq[k], k % 3);
        idle_all();

        // Beat quota: master 1 streams, master 2 waits
        do_reset();
        ack_en = 1'b1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2000_0000);
        drive(2, 1'b1, 1'b1, 1'b0, 32'h3000_0000);
        acks = 0;
        rty_seen = 1'b0;
        for (int c = 0; c < 200 && !rty_seen; c++) begin
            step();
            if (c == 0) check("t3_grant", grant, 3'b010);
            if (bus.m_ack_o[1]) acks++;
            if (bus.m_rty_o[1]) begin
                rty_seen = 1'b1;
                check("t3_rty_stb", bus.p_wb_STB_O, 1'b0);
                check("t3_rty_ack", bus.m_ack_o, 3'b000);
            end
        end
        check("t3_rty_seen", rty_seen, 1'b1);
        check("t3_acks", acks, 64);
        step();
        check("t3_idle", grant, 3'b000);
        step();
        check("t3_next", grant, 3'b100);
        idle_all();

        // Watchdog on a silent slave
        do_reset();
        ack_en = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h5000_0000);
        step();
        check("t4_stb", bus.p_wb_STB_O, 1'b1);
        fired = -1;
        for (int n = 0; n < 300 && fired < 0; n++) begin
            if (tmo) begin
                fired = n;
                check("t4_err", bus.m_err_o, 3'b001);
                check("t4_cyc", bus.p_wb_CYC_O, 1'b0);
                check("t4_stb_low", bus.p_wb_STB_O, 1'b0);
            end else begin
                step();
            end
        end
        check("t4_delay", fired, 255);
        idle_all();
        step();
        check("t4_release", grant, 3'b000);
        check("t4_tmo_pulse", tmo, 1'b0);

        // LOCK keeps master 2 granted across a CYC gap
        do_reset();
        ack_en = 1'b1;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h6000_0000);
        step();
        check("t5_grant", grant, 3'b100);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h7000_0000);
        step();
        drive(2, 1'b0, 1'b0, 1'b1, 32'h6000_0000);
        #1;
        check("t5_cyc_gap", bus.p_wb_CYC_O, 1'b0);
        check("t5_lock_o", bus.p_wb_LOCK_O, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_hold", grant, 3'b100);
        end
        drive(2, 1'b1, 1'b1, 1'b1, 32'h6000_0004);
        step();
        check("t5_resume", grant, 3'b100);
        check("t5_ack", bus.m_ack_o, 3'b100);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("t5_idle", grant, 3'b000);
        step();
        check("t5_m0", grant, 3'b001);
        idle_all();

        // Asynchronous reset in the middle of a burst
        do_reset();
        ack_en = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h4200_0000);
        step();
        step();
        check("t6_pre_ack", bus.m_ack_o, 3'b001);
        rst = 1'b1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h4300_0000);
        #1;
        check("t6_cyc", bus.p_wb_CYC_O, 1'b0);
        check("t6_stb", bus.p_wb_STB_O, 1'b0);
        check("t6_ack", bus.m_ack_o, 3'b000);
        check("t6_grant", grant, 3'b000);
        check("t6_sel", bus.p_wb_SEL_O, 4'hF);
        check("t6_dat_o", bus.m_dat_o, 32'h0);
        step();
        check("t6_ack_hold", bus.m_ack_o, 3'b000);
        rst = 1'b0;
        step();
        check("t6_restart", grant, 3'b001);
        idle_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
